// File: rtl/gps_pkg.sv
`default_nettype none
// ============================================================================
// gps_pkg : shared types and constants for the correlator integrate-and-dump
// Rev 1.0 : initial release
// ============================================================================
package gps_pkg;
    localparam int c_acc_w = 16;
    localparam int c_cnt_w = 16;

    // A mixer product bit of 1 stands for -1, a bit of 0 for +1.
    localparam logic c_bit_minus = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        INTEGRATE = 2'd2
    } corr_state_t;
endpackage
`default_nettype wire

// File: rtl/corr_arm.sv
`default_nettype none
// ============================================================================
// corr_arm : one saturating +/-1 accumulator with clear, add-enable and a
//            sticky (per-interval) saturation flag
// Rev 1.0  : initial release
// ============================================================================
module corr_arm
    import gps_pkg::*;
#(
    parameter int ACC_W = c_acc_w
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_clr,
    input  logic                    i_add,
    input  logic                    i_bit,
    output logic signed [ACC_W-1:0] o_acc_nxt,
    output logic                    o_sat_nxt
);
    localparam logic signed [ACC_W-1:0] c_max = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_min = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] c_one = {{(ACC_W-1){1'b0}}, 1'b1};

    logic signed [ACC_W-1:0] r_acc;
    logic                    r_sat;
    logic signed [ACC_W-1:0] w_acc_nxt;
    logic                    w_clamp;

    // The next value includes this cycle's sample so the parent can dump it.
    always_comb begin
        w_acc_nxt = r_acc;
        w_clamp   = 1'b0;
        if (i_add) begin
            if (i_bit == c_bit_minus) begin
                if (r_acc == c_min) w_clamp   = 1'b1;
                else                w_acc_nxt = r_acc - c_one;
            end else begin
                if (r_acc == c_max) w_clamp   = 1'b1;
                else                w_acc_nxt = r_acc + c_one;
            end
        end
    end

    assign o_acc_nxt = w_acc_nxt;
    assign o_sat_nxt = r_sat | w_clamp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (i_clr) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else begin
            r_acc <= w_acc_nxt;
            r_sat <= o_sat_nxt;
        end
    end
endmodule
`default_nettype wire

// File: rtl/correlator_dump.sv
`default_nettype none
// ============================================================================
// correlator_dump : 1 ms integrate-and-dump of 1-bit prompt products with a
//                   valid/ready dump port. CORR_EARLY_LATE_EN adds E/L arms.
// Rev 1.0         : initial release
// ============================================================================
module correlator_dump
    import gps_pkg::*;
#(
    parameter int ACC_W = c_acc_w,
    parameter int CNT_W = c_cnt_w
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    sample_valid,
    input  logic                    prompt_i,
    input  logic                    prompt_q,
    input  logic                    epoch,
    input  logic                    dump_ready,
    output logic                    dump_valid,
    output logic signed [ACC_W-1:0] dump_i,
    output logic signed [ACC_W-1:0] dump_q,
    output logic        [CNT_W-1:0] dump_count,
    output logic                    dump_sat,
    output logic                    overrun
`ifdef CORR_EARLY_LATE_EN
    ,
    input  logic                    early_i,
    input  logic                    early_q,
    input  logic                    late_i,
    input  logic                    late_q,
    output logic signed [ACC_W-1:0] dump_ei,
    output logic signed [ACC_W-1:0] dump_eq,
    output logic signed [ACC_W-1:0] dump_li,
    output logic signed [ACC_W-1:0] dump_lq
`endif
);
`ifdef CORR_EARLY_LATE_EN
    localparam int c_n_arms = 6;
`else
    localparam int c_n_arms = 2;
`endif
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    corr_state_t             r_state;
    logic                    r_en_d;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    w_integ;
    logic                    w_add;
    logic                    w_dump;
    logic                    w_clr;
    logic [c_n_arms-1:0]     w_arm_bit;
    logic [c_n_arms-1:0]     w_arm_sat;
    logic signed [ACC_W-1:0] w_arm_nxt [c_n_arms];

    assign w_arm_bit[0] = prompt_i;
    assign w_arm_bit[1] = prompt_q;
`ifdef CORR_EARLY_LATE_EN
    assign w_arm_bit[2] = early_i;
    assign w_arm_bit[3] = early_q;
    assign w_arm_bit[4] = late_i;
    assign w_arm_bit[5] = late_q;
`endif

    assign w_integ = enable && (r_state == INTEGRATE);
    assign w_add   = w_integ && sample_valid;
    assign w_dump  = w_integ && epoch;
    // Accumulators sit at zero outside INTEGRATE and restart after each dump.
    assign w_clr   = !w_integ || epoch;

    assign w_cnt_nxt = (w_add && (r_cnt != c_cnt_max)) ? r_cnt + c_cnt_one : r_cnt;

    for (genvar g = 0; g < c_n_arms; g++) begin : g_arm
        corr_arm #(.ACC_W(ACC_W)) u_arm (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_clr     (w_clr),
            .i_add     (w_add),
            .i_bit     (w_arm_bit[g]),
            .o_acc_nxt (w_arm_nxt[g]),
            .o_sat_nxt (w_arm_sat[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_en_d     <= 1'b0;
            r_cnt      <= '0;
            dump_valid <= 1'b0;
            dump_i     <= '0;
            dump_q     <= '0;
            dump_count <= '0;
            dump_sat   <= 1'b0;
            overrun    <= 1'b0;
`ifdef CORR_EARLY_LATE_EN
            dump_ei    <= '0;
            dump_eq    <= '0;
            dump_li    <= '0;
            dump_lq    <= '0;
`endif
        end else begin
            r_en_d <= enable;
            r_cnt  <= w_clr ? '0 : w_cnt_nxt;

            if (enable && !r_en_d) overrun <= 1'b0;

            // A new dump wins over a same-cycle read; only an unread overwrite is an overrun.
            if (w_dump) begin
                dump_valid <= 1'b1;
                dump_i     <= w_arm_nxt[0];
                dump_q     <= w_arm_nxt[1];
                dump_count <= w_cnt_nxt;
                dump_sat   <= |w_arm_sat;
`ifdef CORR_EARLY_LATE_EN
                dump_ei    <= w_arm_nxt[2];
                dump_eq    <= w_arm_nxt[3];
                dump_li    <= w_arm_nxt[4];
                dump_lq    <= w_arm_nxt[5];
`endif
                if (dump_valid && !dump_ready) overrun <= 1'b1;
            end else if (dump_valid && dump_ready) begin
                dump_valid <= 1'b0;
            end

            if (!enable) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE:      r_state <= ARMED;
                    ARMED:     if (epoch) r_state <= INTEGRATE;
                    INTEGRATE: r_state <= INTEGRATE;
                    default:   r_state <= IDLE;
                endcase
            end
        end
    end
endmodule
`default_nettype wire
